prog_seq_detector: RTL and testbench

PROG_SEQ_DETECTOR -- requirements
Module: prog_seq_detector

---
 rtl/prog_seq_detector.sv | 83 ++++++++
 tb/tb_prog_seq_detector.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/prog_seq_detector.sv
// rtl/prog_seq_detector.sv - programmable serial pattern detector with saturating match counter
module prog_seq_detector #(
    parameter int          N           = 8,
    parameter int          CNT_W       = 8,
    parameter logic [N-1:0] DEF_PATTERN = N'(8'b0000_0110),
    parameter int          DEF_LEN     = 4,
    parameter bit          DEF_OVERLAP = 1'b1,
    localparam int         LW          = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             clr_count,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    logic [N-1:0]  hist;
    logic [LW-1:0] fill;
    logic [N-1:0]  pattern;
    logic [LW-1:0] len;
    logic          overlap;

    logic [N-1:0]  hist_new;
    logic [N-1:0]  mask;
    logic          enough;
    logic          hit;
    logic [LW-1:0] fill_inc;
    logic [LW-1:0] len_clamped;

    always_comb begin
        hist_new = {hist[N-2:0], x};
        for (int i = 0; i < N; i++) begin
            mask[i] = (i < int'(len));
        end
        // one extra bit so fill+1 cannot wrap when fill == N
        enough      = ({1'b0, fill} + 1'b1) >= {1'b0, len};
        hit         = in_valid && !cfg_load && (len != '0) && enough &&
                      (((hist_new ^ pattern) & mask) == '0);
        fill_inc    = (fill == LW'(N)) ? fill : fill + 1'b1;
        len_clamped = (cfg_len > LW'(N)) ? LW'(N) : cfg_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= DEF_PATTERN;
            len     <= LW'(DEF_LEN);
            overlap <= DEF_OVERLAP;
            z       <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
            fill    <= '0;
            z       <= 1'b0;
        end else if (in_valid) begin
            hist <= hist_new;
            // non-overlap mode restarts the window so no bit is shared between matches
            fill <= (hit && !overlap) ? '0 : fill_inc;
            z    <= hit;
        end else begin
            z <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (clr_count) begin
            match_count <= '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_seq_detector.sv
// tb/tb_prog_seq_detector.sv - scoreboard bench for prog_seq_detector
module tb_prog_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       in_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       clr_count = 1'b0;
    logic       z, z2;
    logic [7:0] mc;
    logic [1:0] mc2;

    typedef struct {
        logic       z;
        logic [7:0] c;
        logic [1:0] c2;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] ecnt = 8'd0;
    logic [1:0] ecnt2 = 2'd0;

    prog_seq_detector dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr_count(clr_count), .z(z), .match_count(mc)
    );

    prog_seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr_count(clr_count), .z(z2), .match_count(mc2)
    );

    always #5 clk = ~clk;

    // monitor: one expected record per clock edge, checked on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (z !== e.z) begin
                miscompares++;
                $display("FAIL z @%0t: got %b want %b", $time, z, e.z);
            end
            if (z2 !== e.z) begin
                miscompares++;
                $display("FAIL z2 @%0t: got %b want %b", $time, z2, e.z);
            end
            if (mc !== e.c) begin
                miscompares++;
                $display("FAIL match_count @%0t: got %0d want %0d", $time, mc, e.c);
            end
            if (mc2 !== e.c2) begin
                miscompares++;
                $display("FAIL match_count_sat @%0t: got %0d want %0d", $time, mc2, e.c2);
            end
        end
    end

    task automatic step(input logic xi, input logic vi, input logic li,
                        input logic ci, input logic ez);
        exp_t e;
        x = xi; in_valid = vi; cfg_load = li; clr_count = ci;
        if (ci) begin
            ecnt = 8'd0; ecnt2 = 2'd0;
        end else if (ez) begin
            if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
            if (ecnt2 != 2'd3) ecnt2 = ecnt2 + 2'd1;
        end
        @(posedge clk);
        e.z = ez; e.c = ecnt; e.c2 = ecnt2;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
    endtask

    // x held at 1 with in_valid=1 during load: the bit must be ignored
    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
        cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // bits[n-1] is sent first; ez[n-1] is the z expected after the first bit
    task automatic stream(input logic [15:0] bits, input logic [15:0] ez, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, 1'b0, ez[i]);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        ecnt = 8'd0; ecnt2 = 2'd0;
        x = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        e.z = 1'b0; e.c = 8'd0; e.c2 = 2'd0;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        do_reset();

        // overlap with defaults: 0110 len 4
        stream(16'b0110110, 16'b0001001, 7);

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b0110, 4'd4, 1'b0);
        stream(16'b0110110, 16'b0001000, 7);

        // valid gap
        load(8'b101, 4'd3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // len 0 disables detection
        load(8'b0110, 4'd0, 1'b1);
        stream(16'b0110, 16'b0000, 4);

        // len 15 clamps to 8
        load(8'hA5, 4'd15, 1'b1);
        stream(16'hA5, 16'b0000_0001, 8);

        // saturation: 5 matches of 01
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b01, 4'd2, 1'b1);
        stream(16'b0101010101, 16'b0101010101, 10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // reset mid-sequence discards partial progress
        load(8'b0110, 4'd4, 1'b1);
        stream(16'b011, 16'b000, 3);
        do_reset();
        stream(16'b0, 16'b0, 1);
        stream(16'b0110, 16'b0001, 4);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d records left want 0", sb.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
